// File: rtl/usbfs_rx_xact.sv
// rtl/usbfs_rx_xact.sv - USB full-speed OUT/SETUP receive transaction engine
//
// Qualifies OUT/SETUP tokens addressed to this device, evaluates the DATA0/1
// packet that follows against the per-endpoint data toggle, requests an
// ACK/NAK handshake, and streams accepted payload bytes from the receiver
// buffer to the endpoint sink.
//
// Ports:
//   i_clk_48MHz, i_rst_n              clock, asynchronous active-low reset
//   i_devAddr                         device address assigned by the host
//   i_epReady[N_EP]                   endpoint sink can take a full packet
//   i_eop, i_pid, i_addr, i_endp      packet receiver results, valid on i_eop
//   i_pidOkay, i_tokenOkay            PID check / CRC5 of the last packet
//   i_dataOkay, i_rdNBytes            CRC16 / payload byte count
//   o_rdEn, o_rdIdx, i_rdByte         receiver buffer read port, 1-cycle latency
//   o_hsReq, o_hsPid                  one-cycle handshake request (ACK/NAK)
//   o_wrValid, i_wrReady, o_wrByte    payload stream with backpressure
//   o_wrEp, o_wrSetup, o_wrLast       payload sideband
//   o_busy                            transaction in progress

module usbfs_rx_xact #(
    parameter int MAX_PKT = 8,
    parameter int N_EP    = 2,
    parameter int TIMEOUT = 816
) (
    input  logic                       i_clk_48MHz,
    input  logic                       i_rst_n,
    input  logic [6:0]                 i_devAddr,
    input  logic [N_EP-1:0]            i_epReady,
    input  logic                       i_eop,
    input  logic [3:0]                 i_pid,
    input  logic [6:0]                 i_addr,
    input  logic [3:0]                 i_endp,
    input  logic                       i_pidOkay,
    input  logic                       i_tokenOkay,
    input  logic                       i_dataOkay,
    input  logic [$clog2(MAX_PKT):0]   i_rdNBytes,
    output logic                       o_rdEn,
    output logic [$clog2(MAX_PKT)-1:0] o_rdIdx,
    input  logic [7:0]                 i_rdByte,
    output logic                       o_hsReq,
    output logic [3:0]                 o_hsPid,
    output logic                       o_wrValid,
    input  logic                       i_wrReady,
    output logic [7:0]                 o_wrByte,
    output logic [3:0]                 o_wrEp,
    output logic                       o_wrSetup,
    output logic                       o_wrLast,
    output logic                       o_busy
);

    localparam int IW  = $clog2(MAX_PKT);
    localparam int NW  = IW + 1;
    localparam int EPW = (N_EP > 1) ? $clog2(N_EP) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [NW-1:0] MAX_N    = NW'(MAX_PKT);
    localparam logic [4:0]    N_EP_W   = 5'(N_EP);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DATAWAIT = 2'd1;
    localparam logic [1:0] COPY     = 2'd2;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    logic [1:0]      state;
    logic [N_EP-1:0] toggle;
    logic [3:0]      curEp;
    logic            isSetup;
    logic [TW-1:0]   tmoCnt;
    logic [NW-1:0]   nBytes;
    logic [NW-1:0]   rdCnt;

    // Read in flight (byte arrives on i_rdByte this cycle) plus a one-entry
    // skid so a read issued just before a stall is never lost.
    logic            rdPend;
    logic            rdPendLast;
    logic            skidValid;
    logic            skidLast;
    logic [7:0]      skidByte;

    logic            tokenHit;
    logic            isData;
    logic            dataGood;
    logic [EPW-1:0]  epIdx;
    logic            curTog;
    logic            pidTog;
    logic            epRdy;
    logic            doNak;
    logic            doCopy;
    logic            slotFree;

    always_comb begin
        tokenHit = i_eop && (i_pid == PID_OUT || i_pid == PID_SETUP) && i_pidOkay
                   && i_tokenOkay && (i_addr == i_devAddr) && ({1'b0, i_endp} < N_EP_W);
        isData   = (i_pid == PID_DATA0) || (i_pid == PID_DATA1);
        dataGood = i_pidOkay && i_dataOkay && (i_rdNBytes <= MAX_N);
        epIdx    = curEp[EPW-1:0];
        curTog   = toggle[epIdx];
        pidTog   = i_pid[3];
        epRdy    = i_epReady[epIdx];
        doNak    = !isSetup && !epRdy;
        // SETUP payload is only taken from DATA0; OUT payload only when the
        // PID matches the expected toggle (a mismatch is a retransmission).
        doCopy   = isSetup ? !pidTog : (epRdy && (pidTog == curTog));
        slotFree = !o_wrValid || i_wrReady;
        o_rdEn   = (state == COPY) && (rdCnt < nBytes) && slotFree && !(skidValid && rdPend);
        o_rdIdx  = rdCnt[IW-1:0];
        o_busy   = (state != IDLE);
    end

    always_ff @(posedge i_clk_48MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            toggle  <= '0;
            curEp   <= '0;
            isSetup <= 1'b0;
            tmoCnt  <= '0;
            nBytes  <= '0;
            rdCnt   <= '0;
            o_hsReq <= 1'b0;
            o_hsPid <= '0;
        end else begin
            o_hsReq <= 1'b0;
            case (state)
                IDLE: begin
                    if (tokenHit) begin
                        curEp   <= i_endp;
                        isSetup <= (i_pid == PID_SETUP);
                        tmoCnt  <= '0;
                        state   <= DATAWAIT;
                    end
                end
                DATAWAIT: begin
                    if (i_eop && isData) begin
                        state <= IDLE;
                        if (dataGood) begin
                            o_hsReq <= 1'b1;
                            o_hsPid <= doNak ? PID_NAK : PID_ACK;
                            if (isSetup)
                                toggle[epIdx] <= 1'b1;
                            else if (doCopy)
                                toggle[epIdx] <= ~curTog;
                            if (doCopy && i_rdNBytes != '0) begin
                                nBytes <= i_rdNBytes;
                                rdCnt  <= '0;
                                state  <= COPY;
                            end
                        end
                    end else if (i_eop) begin
                        // Aborted by a non-DATA packet, which may itself be a
                        // fresh token for us.
                        if (tokenHit) begin
                            curEp   <= i_endp;
                            isSetup <= (i_pid == PID_SETUP);
                            tmoCnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (tmoCnt == TMO_LAST) begin
                        state <= IDLE;
                    end else begin
                        tmoCnt <= tmoCnt + 1'b1;
                    end
                end
                COPY: begin
                    if (o_rdEn)
                        rdCnt <= rdCnt + 1'b1;
                    if (o_wrValid && i_wrReady && o_wrLast)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_48MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdPend     <= 1'b0;
            rdPendLast <= 1'b0;
            skidValid  <= 1'b0;
            skidLast   <= 1'b0;
            skidByte   <= '0;
            o_wrValid  <= 1'b0;
            o_wrByte   <= '0;
            o_wrEp     <= '0;
            o_wrSetup  <= 1'b0;
            o_wrLast   <= 1'b0;
        end else begin
            rdPend     <= o_rdEn;
            rdPendLast <= (rdCnt == nBytes - 1'b1);
            if (slotFree) begin
                if (skidValid) begin
                    o_wrValid <= 1'b1;
                    o_wrByte  <= skidByte;
                    o_wrLast  <= skidLast;
                    o_wrEp    <= curEp;
                    o_wrSetup <= isSetup;
                    skidValid <= rdPend;
                    skidByte  <= i_rdByte;
                    skidLast  <= rdPendLast;
                end else if (rdPend) begin
                    o_wrValid <= 1'b1;
                    o_wrByte  <= i_rdByte;
                    o_wrLast  <= rdPendLast;
                    o_wrEp    <= curEp;
                    o_wrSetup <= isSetup;
                end else begin
                    o_wrValid <= 1'b0;
                    o_wrLast  <= 1'b0;
                end
            end else if (rdPend) begin
                skidValid <= 1'b1;
                skidByte  <= i_rdByte;
                skidLast  <= rdPendLast;
            end
        end
    end

endmodule

// File: tb/tb_usbfs_rx_xact.sv
// tb/tb_usbfs_rx_xact.sv - self-checking bench for usbfs_rx_xact

module tb_usbfs_rx_xact;

    localparam int MAX_PKT = 8;
    localparam int N_EP    = 2;
    localparam int TIMEOUT = 816;

    localparam logic [3:0] P_OUT   = 4'b0001;
    localparam logic [3:0] P_IN    = 4'b1001;
    localparam logic [3:0] P_SOF   = 4'b0101;
    localparam logic [3:0] P_SETUP = 4'b1101;
    localparam logic [3:0] P_D0    = 4'b0011;
    localparam logic [3:0] P_D1    = 4'b1011;
    localparam logic [3:0] P_ACK   = 4'b0010;
    localparam logic [3:0] P_NAK   = 4'b1010;
    localparam logic [6:0] DEV     = 7'd5;

    logic            i_clk_48MHz = 1'b0;
    logic            i_rst_n     = 1'b0;
    logic [6:0]      i_devAddr   = DEV;
    logic [N_EP-1:0] i_epReady   = '1;
    logic            i_eop       = 1'b0;
    logic [3:0]      i_pid       = '0;
    logic [6:0]      i_addr      = '0;
    logic [3:0]      i_endp      = '0;
    logic            i_pidOkay   = 1'b0;
    logic            i_tokenOkay = 1'b0;
    logic            i_dataOkay  = 1'b0;
    logic [3:0]      i_rdNBytes  = '0;
    logic            o_rdEn;
    logic [2:0]      o_rdIdx;
    logic [7:0]      i_rdByte    = '0;
    logic            o_hsReq;
    logic [3:0]      o_hsPid;
    logic            o_wrValid;
    logic            i_wrReady   = 1'b1;
    logic [7:0]      o_wrByte;
    logic [3:0]      o_wrEp;
    logic            o_wrSetup;
    logic            o_wrLast;
    logic            o_busy;

    usbfs_rx_xact #(.MAX_PKT(MAX_PKT), .N_EP(N_EP), .TIMEOUT(TIMEOUT)) dut (
        .i_clk_48MHz(i_clk_48MHz), .i_rst_n(i_rst_n), .i_devAddr(i_devAddr),
        .i_epReady(i_epReady), .i_eop(i_eop), .i_pid(i_pid), .i_addr(i_addr),
        .i_endp(i_endp), .i_pidOkay(i_pidOkay), .i_tokenOkay(i_tokenOkay),
        .i_dataOkay(i_dataOkay), .i_rdNBytes(i_rdNBytes), .o_rdEn(o_rdEn),
        .o_rdIdx(o_rdIdx), .i_rdByte(i_rdByte), .o_hsReq(o_hsReq), .o_hsPid(o_hsPid),
        .o_wrValid(o_wrValid), .i_wrReady(i_wrReady), .o_wrByte(o_wrByte),
        .o_wrEp(o_wrEp), .o_wrSetup(o_wrSetup), .o_wrLast(o_wrLast), .o_busy(o_busy)
    );

    initial forever #10 i_clk_48MHz = ~i_clk_48MHz;

    int tests = 0;
    int fails = 0;

    // Reference model: per-endpoint toggles and pending-token context.
    bit        mTog [N_EP];
    bit        mWait = 0;
    int        mEp = 0;
    bit        mSetup = 0;
    int        hsCount = 0;
    int        expHsCount = 0;

    logic [7:0]  rxBuf [MAX_PKT+2];
    logic [13:0] gotQ [$];
    logic [13:0] expQ [$];
    int          readyMode = 0;
    int          rdExp = 0;
    bit          rdGo = 0;
    logic [7:0]  rdNext = '0;
    bit          stallPrev = 0;
    logic [14:0] stallVals = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: handshakes, delivered bytes, read order, stall stability.
    initial forever begin
        @(negedge i_clk_48MHz);
        if (i_rst_n) begin
            if (o_hsReq) hsCount++;
            if (o_wrValid && i_wrReady) gotQ.push_back({o_wrEp, o_wrSetup, o_wrLast, o_wrByte});
            if (stallPrev)
                chk("stall_stable", {17'd0, o_wrValid, o_wrEp, o_wrSetup, o_wrLast, o_wrByte}, {17'd0, stallVals});
            stallPrev = o_wrValid && !i_wrReady;
            stallVals = {o_wrValid, o_wrEp, o_wrSetup, o_wrLast, o_wrByte};
            if (o_rdEn) begin
                chk("rd_idx", {29'd0, o_rdIdx}, rdExp);
                rdExp++;
                rdNext = rxBuf[o_rdIdx];
                rdGo = 1;
            end else begin
                rdGo = 0;
            end
        end else begin
            stallPrev = 0;
            rdGo = 0;
        end
    end

    // Receiver buffer read data and sink readiness.
    initial forever begin
        @(posedge i_clk_48MHz);
        #1;
        i_rdByte = rdGo ? rdNext : 8'($urandom);
        case (readyMode)
            0: i_wrReady = 1'b1;
            1: i_wrReady = ~i_wrReady;
            default: i_wrReady = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                         input bit pOk, input bit tOk, input bit dOk, input int n);
        @(posedge i_clk_48MHz);
        #1;
        i_pid = pid; i_addr = addr; i_endp = endp;
        i_pidOkay = pOk; i_tokenOkay = tOk; i_dataOkay = dOk;
        i_rdNBytes = 4'(n);
        i_eop = 1'b1;
        @(posedge i_clk_48MHz);
        #1;
        i_eop = 1'b0;
        i_pid = 4'($urandom); i_addr = 7'($urandom); i_endp = 4'($urandom);
        i_pidOkay = 1'($urandom); i_tokenOkay = 1'($urandom); i_dataOkay = 1'($urandom);
        i_rdNBytes = 4'($urandom);
    endtask

    task automatic doToken(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep,
                           input bit tOk, input string tag);
        bit qual;
        qual = (pid == P_OUT || pid == P_SETUP) && tOk && addr == DEV && int'(ep) < N_EP;
        mWait = qual;
        if (qual) begin
            mEp = int'(ep);
            mSetup = (pid == P_SETUP);
        end
        pulse(pid, addr, ep, 1'b1, tOk, 1'($urandom), int'($urandom_range(0, 8)));
        @(negedge i_clk_48MHz);
        chk({tag, ".tok_busy"}, {31'd0, o_busy}, {31'd0, qual});
        chk({tag, ".tok_hs"}, {31'd0, o_hsReq}, 0);
    endtask

    task automatic waitIdle(input string tag);
        int k = 0;
        while (o_busy && k < 300) begin
            @(negedge i_clk_48MHz);
            k++;
        end
        chk({tag, ".idle"}, {31'd0, o_busy}, 0);
    endtask

    // mode: 0 plain, 1 token arrives during copy, 2 reset during copy
    task automatic doData(input logic [3:0] pid, input bit pOk, input bit dOk, input int n,
                          input logic [N_EP-1:0] rdy, input int mode, input string tag);
        bit         expHs = 0;
        bit         copy = 0;
        logic [3:0] expPid = P_ACK;
        i_epReady = rdy;
        if (mWait && pOk && dOk && n <= MAX_PKT) begin
            expHs = 1;
            if (mSetup) begin
                copy = (pid == P_D0);
                mTog[mEp] = 1;
            end else if (!rdy[mEp]) begin
                expPid = P_NAK;
            end else if ((pid == P_D1) == mTog[mEp]) begin
                copy = 1;
                mTog[mEp] = !mTog[mEp];
            end
        end
        if (copy)
            for (int i = 0; i < n; i++)
                expQ.push_back({4'(mEp), mSetup, (i == n - 1), rxBuf[i]});
        if (expHs) expHsCount++;
        mWait = 0;
        rdExp = 0;
        pulse(pid, 7'($urandom), 4'($urandom), pOk, 1'($urandom), dOk, n);
        @(negedge i_clk_48MHz);
        chk({tag, ".hsReq"}, {31'd0, o_hsReq}, {31'd0, expHs});
        if (expHs) chk({tag, ".hsPid"}, {28'd0, o_hsPid}, {28'd0, expPid});
        if (mode == 1) begin
            repeat (2) @(posedge i_clk_48MHz);
            pulse(P_OUT, DEV, 4'd1, 1'b1, 1'b1, 1'b1, 3);
            @(negedge i_clk_48MHz);
            chk({tag, ".copy_busy"}, {31'd0, o_busy}, 1);
        end
        if (mode == 2) begin
            repeat (4) @(posedge i_clk_48MHz);
            #3;
            i_rst_n = 1'b0;
            #1;
            chk({tag, ".rst_out"},
                {o_rdEn, o_hsReq, o_wrValid, o_wrLast, o_wrSetup, o_busy, o_rdIdx, o_wrByte, o_wrEp, o_hsPid},
                '0);
            for (int i = 0; i < N_EP; i++) mTog[i] = 0;
            gotQ.delete();
            expQ.delete();
            @(posedge i_clk_48MHz);
            #1;
            i_rst_n = 1'b1;
            @(negedge i_clk_48MHz);
            chk({tag, ".rst_idle"}, {31'd0, o_busy}, 0);
        end else begin
            waitIdle(tag);
            chk({tag, ".nbytes"}, gotQ.size(), expQ.size());
            for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
                chk({tag, ".byte"}, {18'd0, gotQ[i]}, {18'd0, expQ[i]});
            gotQ.delete();
            expQ.delete();
        end
        chk({tag, ".hsCount"}, hsCount, expHsCount);
    endtask

    function automatic logic [3:0] nextPid(input int ep);
        return mTog[ep] ? P_D1 : P_D0;
    endfunction

    initial begin
        for (int i = 0; i < N_EP; i++) mTog[i] = 0;
        for (int i = 0; i < MAX_PKT + 2; i++) rxBuf[i] = 8'($urandom);
        repeat (3) @(posedge i_clk_48MHz);
        @(negedge i_clk_48MHz);
        chk("reset.busy", {31'd0, o_busy}, 0);
        chk("reset.outs",
            {o_rdEn, o_hsReq, o_wrValid, o_wrLast, o_wrSetup, o_rdIdx, o_wrByte, o_wrEp, o_hsPid}, '0);
        #1 i_rst_n = 1'b1;

        // Sequential OUTs on ep1
        doToken(P_OUT, DEV, 4'd1, 1, "seq0");
        rxBuf[0] = 8'hAA; rxBuf[1] = 8'hBB; rxBuf[2] = 8'hCC;
        doData(P_D0, 1, 1, 3, 2'b11, 0, "seq0");
        doToken(P_OUT, DEV, 4'd1, 1, "seq1");
        rxBuf[0] = 8'h11; rxBuf[1] = 8'h22;
        doData(P_D1, 1, 1, 2, 2'b11, 0, "seq1");
        doToken(P_OUT, DEV, 4'd1, 1, "dup");
        doData(P_D1, 1, 1, 2, 2'b11, 0, "dup");

        // SETUP on ep0 after toggle[0] has been set
        doToken(P_OUT, DEV, 4'd0, 1, "ep0out");
        doData(P_D0, 1, 1, 1, 2'b11, 0, "ep0out");
        doToken(P_SETUP, DEV, 4'd0, 1, "setup");
        for (int i = 0; i < MAX_PKT; i++) rxBuf[i] = 8'(8'h40 + i);
        doData(P_D0, 1, 1, 8, 2'b00, 0, "setup");
        doToken(P_OUT, DEV, 4'd0, 1, "ep0dup");
        doData(P_D0, 1, 1, 4, 2'b11, 0, "ep0dup");

        // NAK
        doToken(P_OUT, DEV, 4'd1, 1, "nak");
        doData(nextPid(1), 1, 1, 4, 2'b01, 0, "nak");

        // No handshake cases
        doToken(P_OUT, 7'd6, 4'd1, 1, "badaddr");
        doData(P_D0, 1, 1, 2, 2'b11, 0, "badaddr");
        doToken(P_OUT, DEV, 4'd1, 1, "badcrc");
        doData(nextPid(1), 1, 0, 2, 2'b11, 0, "badcrc");
        doToken(P_OUT, DEV, 4'd1, 1, "oversize");
        doData(nextPid(1), 1, 1, MAX_PKT + 1, 2'b11, 0, "oversize");
        doToken(P_OUT, DEV, 4'd1, 1, "tmo");
        repeat (TIMEOUT - 10) @(negedge i_clk_48MHz);
        chk("tmo.waiting", {31'd0, o_busy}, 1);
        repeat (15) @(negedge i_clk_48MHz);
        chk("tmo.idle", {31'd0, o_busy}, 0);
        chk("tmo.hsCount", hsCount, expHsCount);
        mWait = 0;

        // Non-DATA packet in DATAWAIT re-evaluated as a new token
        doToken(P_OUT, DEV, 4'd1, 1, "reeval");
        doToken(P_SETUP, DEV, 4'd0, 1, "reeval");
        doData(P_D0, 1, 1, 2, 2'b00, 0, "reeval");

        // Backpressure with a token arriving mid-copy
        readyMode = 1;
        doToken(P_OUT, DEV, 4'd1, 1, "bp");
        for (int i = 0; i < MAX_PKT; i++) rxBuf[i] = 8'($urandom);
        doData(nextPid(1), 1, 1, 8, 2'b11, 1, "bp");

        // Asynchronous reset mid-copy, then toggles must be back to 0
        doToken(P_OUT, DEV, 4'd1, 1, "rst");
        doData(nextPid(1), 1, 1, 8, 2'b11, 2, "rst");
        readyMode = 0;
        doToken(P_OUT, DEV, 4'd1, 1, "postrst");
        doData(P_D0, 1, 1, 3, 2'b11, 0, "postrst");

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            logic [3:0] tp;
            logic [3:0] dp;
            int r;
            readyMode = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 9));
            tp = (r < 5) ? P_OUT : (r < 8) ? P_SETUP : (r == 8) ? P_IN : P_SOF;
            for (int i = 0; i < MAX_PKT + 2; i++) rxBuf[i] = 8'($urandom);
            doToken(tp, ($urandom_range(0, 4) == 0) ? 7'($urandom) : DEV,
                    4'($urandom_range(0, 2)), ($urandom_range(0, 9) != 0), "rnd");
            dp = $urandom_range(0, 1) ? P_D1 : P_D0;
            doData(dp, ($urandom_range(0, 19) != 0), ($urandom_range(0, 9) != 0),
                   int'($urandom_range(0, MAX_PKT + 1)), N_EP'($urandom), 0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
